exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle control FSM for the matrix processor. Owns the program counter and
//  sequences fetch -> execute -> commit for each instruction. Gates the data-memory
//  write to exactly one strobe per instruction and terminates a run on the decoder
//  halt flag or on a watchdog timeout. Sits between St/jump and the instr_memory,
//  decoder and data_memory; reports run status to the testbench.
// PARAMETERS
//  PC_W        8     program-counter width (= `INSTR_BIT)
//  EXEC_CYC    2     cycles allowed for data_memory read + ALU settle (>=1)
//  MAX_CYC     4096  watchdog: max cycles per run before forced halt (>=4)
//  CNT_W       16    width of instr_count
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      asynchronous reset, active-high
//  St           in   1      start request, level sampled in IDLE/HALT
//  jump         in   1      global branch enable
//  halt_instr   in   1      decoder "done": current instruction is HALT
//  pc_src       in   1      decoder: current instruction is a branch
//  jump_addr    in   PC_W   decoder: branch target
//  pc           out  PC_W   instruction address to instr_memory
//  wr_en        out  1      one-cycle data_memory write strobe
//  busy         out  1      1 in FETCH/EXEC/COMMIT
//  done         out  1      1 in HALT (sticky until next St)
//  timeout      out  1      1 if the run ended by watchdog (sticky with done)
//  instr_count  out  CNT_W  instructions committed in current run
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pc=0, wr_en=0, busy=0, done=0,
//    timeout=0, instr_count=0, exec/watchdog counters=0. No wr_en on the abort cycle.
//  - States: IDLE, FETCH, EXEC, COMMIT, HALT (registered; outputs decoded from state).
//  - IDLE: St=1 -> FETCH; pc=0, instr_count=0, watchdog=0.
//  - FETCH (1 cyc): decoder outputs valid from pc. halt_instr=1 -> HALT (no write,
//    pc unchanged, count unchanged). Else -> EXEC, exec counter=0.
//  - EXEC: EXEC_CYC cycles, then -> COMMIT. Decoder inputs must stay stable.
//  - COMMIT (1 cyc): wr_en=1; at clock edge pc <= (pc_src & jump) ? jump_addr
//    : pc+1 (mod 2^PC_W, wraps 2^PC_W-1 -> 0); instr_count += 1 saturating at
//    2^CNT_W-1; -> FETCH.
//  - Per-instruction latency: 2+EXEC_CYC cycles; first FETCH one cycle after St
//    sampled in IDLE.
//  - Watchdog counts every busy cycle from the first FETCH. On reaching MAX_CYC
//    in FETCH/EXEC -> HALT with timeout=1, no write. Reaching it in COMMIT: the
//    commit completes (wr_en, pc update), then -> HALT with timeout=1.
//  - HALT: done=1, busy=0; pc, instr_count held. St=1 -> FETCH with pc=0,
//    instr_count=0, done=0, timeout=0 (restart).
//  - St while busy: ignored. jump without pc_src: no effect. Branch to own
//    address is legal (loop; watchdog terminates).
//  - halt_instr and pc_src both 1: halt wins.
// TESTING
//  1 RST mid-EXEC -> same cycle busy=0, pc=0, no wr_en pulse; after release, IDLE.
//  2 Program {ADD,ADD,ADD,HALT}, EXEC_CYC=2, St pulse -> 3 wr_en pulses 4 cycles
//    apart, done=1 at cycle 14 after St, instr_count=3, pc=3.
//  3 Branch at pc=1 to 5, jump=1 -> pc after commit=5; same with jump=0 -> pc=2.
//  4 Self-branch loop, MAX_CYC=64 -> done=1, timeout=1, busy cycles=64.
//  5 PC_W=3, 8 non-halt instrs, then HALT at 0 -> pc wraps 7->0, done, count=8.
//  6 St pulses while busy ignored; St in HALT -> restart, instr_count reset to 0.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the run controller, decoder and the sequencer.
// Pure wiring, no latency of its own.
// No backpressure: level signals sampled by the sequencer every cycle.
interface exec_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic              St;
    logic              jump;
    logic              halt_instr;
    logic              pc_src;
    logic [PC_W-1:0]   jump_addr;
    logic [PC_W-1:0]   pc;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  instr_count;

    // Controller / decoder side: drives start, branch info; observes status.
    modport master (
        output St, jump, halt_instr, pc_src, jump_addr,
        input  pc, wr_en, busy, done, timeout, instr_count
    );

    // Sequencer side.
    modport slave (
        input  St, jump, halt_instr, pc_src, jump_addr,
        output pc, wr_en, busy, done, timeout, instr_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// Fetch/execute/commit sequencer: owns pc, one wr_en per instruction, halt/watchdog stop.
// Latency: first FETCH one cycle after St; 2+EXEC_CYC cycles per committed instruction.
// No backpressure: St is ignored while busy; decoder inputs must hold through EXEC.
module exec_sequencer #(
    parameter int PC_W     = 8,
    parameter int EXEC_CYC = 2,
    parameter int MAX_CYC  = 4096,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    exec_sequencer_if.slave  bus
);
    localparam int EC_W = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
    localparam int WD_W = $clog2(MAX_CYC + 1);
    localparam logic [EC_W-1:0]  EXEC_LAST = EC_W'(EXEC_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(MAX_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_COMMIT = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [EC_W-1:0]   ex_q, ex_d;
    logic              to_q, to_d;
    logic              wd_hit;

    // State and datapath registers; reset aborts any state immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            ex_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            ex_q    <= ex_d;
            to_q    <= to_d;
        end
    end

    // Next state plus pc/count/watchdog updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        ex_d    = ex_q;
        to_d    = to_q;
        // wd_q holds completed busy cycles, so this is the last allowed busy cycle.
        wd_hit  = (wd_q == WD_LAST);
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.St) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    to_d    = 1'b0;
                end
            end
            S_FETCH: begin
                wd_d = wd_q + WD_W'(1);
                // A decoded HALT ends the run cleanly even on the watchdog's last cycle.
                if (bus.halt_instr) begin
                    state_d = S_HALT;
                end else if (wd_hit) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    ex_d    = '0;
                end
            end
            S_EXEC: begin
                wd_d = wd_q + WD_W'(1);
                if (wd_hit) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end else if (ex_q == EXEC_LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    ex_d = ex_q + EC_W'(1);
                end
            end
            S_COMMIT: begin
                wd_d  = wd_q + WD_W'(1);
                pc_d  = (bus.pc_src && bus.jump) ? bus.jump_addr : pc_q + PC_W'(1);
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // The write in flight always completes; the watchdog only blocks the next fetch.
                if (wd_hit) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_COMMIT);
        bus.done        = (state_q == S_HALT);
        bus.wr_en       = (state_q == S_COMMIT);
        bus.pc          = pc_q;
        bus.instr_count = cnt_q;
        bus.timeout     = to_q;
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: table of directed programs, reset aborts, random programs vs run model.
// Decoder is modelled as a small program array indexed by pc.
// St is toggled randomly while busy to show it is ignored.
module tb_exec_sequencer;
    localparam int PC_W = 3, EXEC_CYC = 2, MAX_CYC = 64, CNT_W = 4;
    localparam int NPROG = 8;
    localparam int CNT_SAT = 15;

    logic CLK, RST;
    exec_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) ifc ();

    exec_sequencer #(.PC_W(PC_W), .EXEC_CYC(EXEC_CYC), .MAX_CYC(MAX_CYC), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Program memory + decoder model
    logic            p_halt [NPROG];
    logic            p_br   [NPROG];
    logic [PC_W-1:0] p_tgt  [NPROG];
    assign ifc.halt_instr = p_halt[ifc.pc];
    assign ifc.pc_src     = p_br[ifc.pc];
    assign ifc.jump_addr  = p_tgt[ifc.pc];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic load_prog(input int id);
        for (int i = 0; i < NPROG; i++) begin
            p_halt[i] = 1'b1;
            p_br[i]   = 1'b0;
            p_tgt[i]  = '0;
        end
        case (id)
            0: begin p_halt[0] = 0; p_halt[1] = 0; p_halt[2] = 0; end
            1: begin p_halt[0] = 0; p_halt[1] = 0; p_br[1] = 1; p_tgt[1] = 3'd5; end
            2: begin p_halt[0] = 0; p_br[0] = 1; p_tgt[0] = 3'd0; end
            3: for (int i = 0; i < NPROG; i++) p_halt[i] = 1'b0;
            default: ;
        endcase
    endtask

    // Run-level reference: walk instructions, 2+EXEC_CYC busy cycles per commit.
    int m_wr_cyc[$];
    int m_wr_pc[$];
    task automatic model(input bit jmp, output int e_pc, output int e_cnt,
                         output int e_to, output int e_busy);
        int pc, cyc, cnt, per;
        pc = 0; cyc = 0; cnt = 0; e_to = 0;
        per = 2 + EXEC_CYC;
        m_wr_cyc.delete(); m_wr_pc.delete();
        forever begin
            if (p_halt[pc]) begin cyc += 1; break; end
            if (cyc + per > MAX_CYC) begin cyc = MAX_CYC; e_to = 1; break; end
            cyc += per;
            m_wr_cyc.push_back(cyc);
            m_wr_pc.push_back(pc);
            cnt = (cnt < CNT_SAT) ? cnt + 1 : CNT_SAT;
            pc = (p_br[pc] && jmp) ? int'(p_tgt[pc]) : (pc + 1) % NPROG;
            if (cyc == MAX_CYC) begin e_to = 1; break; end
        end
        e_pc = pc; e_cnt = cnt; e_busy = cyc;
    endtask

    // Observed run
    int r_busy, r_done_cyc;
    bit r_done;
    int r_wr_cyc[$];
    int r_wr_pc[$];

    task automatic run(input bit patch0, input bit noise);
        r_wr_cyc.delete(); r_wr_pc.delete();
        r_busy = 0; r_done = 0; r_done_cyc = 0;
        @(negedge CLK); ifc.St = 1'b1;
        @(negedge CLK); ifc.St = 1'b0;
        chk("start_busy", ifc.busy, 1);
        chk("start_count_zero", ifc.instr_count, 0);
        chk("start_timeout_clear", ifc.timeout, 0);
        for (int k = 1; k <= 200; k++) begin
            if (ifc.done) begin r_done = 1; r_done_cyc = k; break; end
            if (ifc.busy) r_busy++;
            if (ifc.wr_en) begin
                r_wr_cyc.push_back(r_busy);
                r_wr_pc.push_back(int'(ifc.pc));
                if (patch0) p_halt[0] = 1'b1;
            end
            ifc.St = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge CLK);
        end
        ifc.St = 1'b0;
        chk("done_reached", r_done, 1);
        chk("done_cycle", r_done_cyc, r_busy + 1);
    endtask

    task automatic cmp_wr();
        chk("wr_pulses_vs_model", r_wr_cyc.size(), m_wr_cyc.size());
        if (r_wr_cyc.size() == m_wr_cyc.size())
            foreach (m_wr_cyc[i]) begin
                chk("wr_cycle", r_wr_cyc[i], m_wr_cyc[i]);
                chk("wr_pc", r_wr_pc[i], m_wr_pc[i]);
            end
    endtask

    task automatic abort(input int at);
        load_prog(0);
        ifc.jump = 1'b0;
        @(negedge CLK); ifc.St = 1'b1;
        @(negedge CLK); ifc.St = 1'b0;
        repeat (at - 1) @(negedge CLK);
        chk("pre_abort_busy", ifc.busy, 1);
        chk("pre_abort_wr_en", ifc.wr_en, (at % 4 == 0) ? 1 : 0);
        #1 RST = 1'b1;
        #1;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_pc", ifc.pc, 0);
        chk("abort_wr_en", ifc.wr_en, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_count", ifc.instr_count, 0);
        @(negedge CLK); RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_busy", ifc.busy, 0);
        chk("idle_done", ifc.done, 0);
    endtask

    typedef struct {
        int id; bit jmp; int e_pc; int e_cnt; int e_to; int e_busy; int e_wr;
    } vec_t;

    initial begin
        vec_t vt[6];
        int e_pc, e_cnt, e_to, e_busy;
        bit jmp;

        vt[0] = '{0, 1'b1, 3, 3, 0, 13, 3};
        vt[1] = '{0, 1'b0, 3, 3, 0, 13, 3};
        vt[2] = '{1, 1'b1, 5, 2, 0, 9, 2};
        vt[3] = '{1, 1'b0, 2, 2, 0, 9, 2};
        vt[4] = '{2, 1'b1, 0, CNT_SAT, 1, MAX_CYC, 16};
        vt[5] = '{2, 1'b0, 1, 1, 0, 5, 1};

        RST = 1'b1; ifc.St = 1'b0; ifc.jump = 1'b0;
        load_prog(0);
        repeat (2) @(negedge CLK);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_pc", ifc.pc, 0);
        chk("rst_wr_en", ifc.wr_en, 0);
        chk("rst_timeout", ifc.timeout, 0);
        chk("rst_count", ifc.instr_count, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_no_start", ifc.busy, 0);

        abort(6);
        abort(8);

        // Directed table
        foreach (vt[i]) begin
            load_prog(vt[i].id);
            ifc.jump = vt[i].jmp;
            model(vt[i].jmp, e_pc, e_cnt, e_to, e_busy);
            run(1'b0, 1'b0);
            chk("tbl_pc", ifc.pc, vt[i].e_pc);
            chk("tbl_count", ifc.instr_count, vt[i].e_cnt);
            chk("tbl_timeout", ifc.timeout, vt[i].e_to);
            chk("tbl_busy_cycles", r_busy, vt[i].e_busy);
            chk("tbl_wr_pulses", r_wr_cyc.size(), vt[i].e_wr);
            cmp_wr();
            repeat (3) @(negedge CLK);
            chk("tbl_done_sticky", ifc.done, 1);
            chk("tbl_pc_held", ifc.pc, vt[i].e_pc);
        end

        // pc wrap: eight ADDs then address 0 becomes HALT on the second visit
        load_prog(3);
        ifc.jump = 1'b0;
        run(1'b1, 1'b0);
        chk("wrap_pc", ifc.pc, 0);
        chk("wrap_count", ifc.instr_count, 8);
        chk("wrap_timeout", ifc.timeout, 0);
        chk("wrap_busy_cycles", r_busy, 33);
        chk("wrap_last_wr_pc", (r_wr_pc.size() == 8) ? r_wr_pc[7] : -1, 7);

        // Random programs, St noise while busy, restarts from HALT
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NPROG; i++) begin
                p_halt[i] = ($urandom_range(0, 3) == 0);
                p_br[i]   = ($urandom_range(0, 2) == 0);
                p_tgt[i]  = PC_W'($urandom_range(0, NPROG - 1));
            end
            jmp = 1'($urandom_range(0, 1));
            ifc.jump = jmp;
            model(jmp, e_pc, e_cnt, e_to, e_busy);
            run(1'b0, 1'b1);
            chk("rnd_pc", ifc.pc, e_pc);
            chk("rnd_count", ifc.instr_count, e_cnt);
            chk("rnd_timeout", ifc.timeout, e_to);
            chk("rnd_busy_cycles", r_busy, e_busy);
            cmp_wr();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
